// File: rtl/tcdm_rr_arbiter.sv
`timescale 1ns/1ps
// tcdm_rr_arbiter
// Round-robin arbiter sharing one TCDM slave port among NR TCDM masters.
// A stalled request stays locked to its requester until granted. Each
// handshake pushes the winner id into a RESP_LAT-deep pipe, which steers
// the returning response. Sequencing problems (unexpected or missing
// response, locked requester dropping req) set the sticky err_o.
// Optional: define TCDM_RR_ARBITER_PERF_EN to add cnt_gnt_o / cnt_stall_o.
module tcdm_rr_arbiter #(
  parameter int unsigned NR       = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [NR-1:0]        req_i,
  input  logic [NR*AW-1:0]     add_i,
  input  logic [NR-1:0]        wen_i,
  input  logic [NR*DW/8-1:0]   be_i,
  input  logic [NR*DW-1:0]     data_i,
  output logic [NR-1:0]        gnt_o,
  output logic [NR*DW-1:0]     r_data_o,
  output logic [NR-1:0]        r_valid_o,
  output logic                 mem_req_o,
  output logic [AW-1:0]        mem_add_o,
  output logic                 mem_wen_o,
  output logic [DW/8-1:0]      mem_be_o,
  output logic [DW-1:0]        mem_data_o,
  input  logic                 mem_gnt_i,
  input  logic [DW-1:0]        mem_r_data_i,
  input  logic                 mem_r_valid_i,
  output logic                 err_o
`ifdef TCDM_RR_ARBITER_PERF_EN
  ,
  output logic [NR*32-1:0]     cnt_gnt_o,
  output logic [31:0]          cnt_stall_o
`endif
);

  localparam int unsigned IW = $clog2(NR);
  localparam int unsigned BW = DW / 8;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_idx_q;
  logic          lock_q;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr_nxt;
  logic          lock_drop;
  logic          any_req;
  logic          hs;
  logic          stall;

  logic          pipe_vld_q [RESP_LAT];
  logic [IW-1:0] pipe_id_q  [RESP_LAT];
  logic          out_vld;
  logic [IW-1:0] out_id;

  assign any_req = |req_i;
  assign hs      = any_req & mem_gnt_i;
  assign stall   = any_req & ~mem_gnt_i;
  assign ptr_nxt = (winner == IW'(NR - 1)) ? '0 : winner + IW'(1);
  assign out_vld = pipe_vld_q[RESP_LAT-1];
  assign out_id  = pipe_id_q[RESP_LAT-1];

  // Winner selection: honour a live lock, otherwise scan from ptr_q upwards.
  // A lock whose requester dropped req is ignored and normal scanning applies.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    int unsigned   idx;
    winner    = '0;
    found     = 1'b0;
    cand      = '0;
    idx       = 0;
    lock_drop = lock_q & ~req_i[lock_idx_q];
    if (lock_q && req_i[lock_idx_q]) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NR) idx = idx - NR;
        cand = IW'(idx);
        if (!found && req_i[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  // Route the winner's request fields downstream and return its grant.
  always_comb begin
    gnt_o      = '0;
    mem_req_o  = any_req;
    mem_add_o  = '0;
    mem_wen_o  = 1'b0;
    mem_be_o   = '0;
    mem_data_o = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (any_req && (winner == IW'(i))) begin
        gnt_o[i]   = mem_gnt_i;
        mem_add_o  = add_i[i*AW +: AW];
        mem_wen_o  = wen_i[i];
        mem_be_o   = be_i[i*BW +: BW];
        mem_data_o = data_i[i*DW +: DW];
      end
    end
  end

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (clear_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      ptr_q  <= ptr_nxt;
      lock_q <= 1'b0;
    end else if (stall) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end else begin
      lock_q <= 1'b0;
    end
  end

  // Response id pipe: one stage per cycle of downstream latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < RESP_LAT; s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_id_q[s]  <= '0;
      end
    end else if (clear_i) begin
      for (int unsigned s = 0; s < RESP_LAT; s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_id_q[s]  <= '0;
      end
    end else begin
      pipe_vld_q[0] <= hs;
      pipe_id_q[0]  <= winner;
      for (int unsigned s = 1; s < RESP_LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
    end
  end

  // Steer the response valid to the requester that issued the handshake.
  always_comb begin
    r_valid_o = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      r_valid_o[i] = mem_r_valid_i & out_vld & (out_id == IW'(i));
    end
  end

  assign r_data_o = {NR{mem_r_data_i}};

  // Sticky sequencing error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (clear_i) begin
      err_o <= 1'b0;
    end else if (lock_drop || (mem_r_valid_i != out_vld)) begin
      err_o <= 1'b1;
    end
  end

`ifdef TCDM_RR_ARBITER_PERF_EN
  logic [31:0] cnt_gnt_q [NR];
  logic [31:0] cnt_stall_q;

  // Saturating handshake counters per requester and stall-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR; i++) cnt_gnt_q[i] <= '0;
      cnt_stall_q <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < NR; i++) cnt_gnt_q[i] <= '0;
      cnt_stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (hs && (winner == IW'(i)) && (cnt_gnt_q[i] != '1)) begin
          cnt_gnt_q[i] <= cnt_gnt_q[i] + 32'd1;
        end
      end
      if (stall && (cnt_stall_q != '1)) begin
        cnt_stall_q <= cnt_stall_q + 32'd1;
      end
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    cnt_gnt_o = '0;
    for (int unsigned i = 0; i < NR; i++) cnt_gnt_o[i*32 +: 32] = cnt_gnt_q[i];
  end

  assign cnt_stall_o = cnt_stall_q;
`endif

endmodule

// File: doc/tcdm_rr_arbiter.md
# tcdm_rr_arbiter

Round-robin arbiter that shares one TCDM slave port (e.g. the testbench dummy memory or a single TCDM bank) among NR TCDM master ports. It sits between the streamer/engine TCDM masters and the memory, routes each grant-time request downstream and steers the fixed-latency response back to the requester that issued it. Requests whose grant is stalled stay locked to their requester, and the returned responses are checked for sequencing errors.

## Interface
- NR, 4: number of requester ports (2..16)
- AW, 32: address width
- DW, 32: data width (byte enables DW/8)
- RESP_LAT, 1: downstream cycles from handshake (req&gnt) to r_valid (1..4)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of pointer, lock, response pipe, err_o (and counters)
- req_i  in  NR  per-requester request
- add_i  in  NR×AW  per-requester address
- wen_i  in  NR  1 = read, 0 = write
- be_i  in  NR×DW/8  byte enables
- data_i  in  NR×DW  write data
- gnt_o  out  NR  per-requester grant
- r_data_o  out  NR×DW  response data (mem_r_data_i broadcast)
- r_valid_o  out  NR  per-requester response valid
- mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o  out  1/AW/1/DW/8/DW  downstream request
- mem_gnt_i  in  1  downstream grant
- mem_r_data_i  in  DW  downstream response data
- mem_r_valid_i  in  1  downstream response valid
- err_o  out  1  sticky: unexpected response or locked requester dropped req

## Operation
- Winner: if lock_q, winner = lock_idx_q; else first i with req_i[i] scanning ptr_q, ptr_q+1, … mod NR.
- mem_req_o = |req_i; mem_add/wen/be/data = winner's fields; zero when no request.
- gnt_o[winner] = mem_gnt_i & mem_req_o; all other gnt_o = 0.
- Handshake (mem_req_o & mem_gnt_i): ptr_q <= (winner+1) mod NR; lock_q <= 0; push {1, winner} into response pipe.
- Stall (mem_req_o & ~mem_gnt_i): lock_q <= 1, lock_idx_q <= winner; ptr_q unchanged. Address/data to memory therefore stable until grant.
- Locked requester deasserts req (protocol violation): lock released same cycle, normal arbitration this cycle, err_o <= 1.
- Response pipe: RESP_LAT-deep shift register of {valid, id}, advancing every cycle; pushes {0,x} when no handshake.
- r_valid_o[i] = mem_r_valid_i & pipe_out.valid & (pipe_out.id == i); r_data_o[all] = mem_r_data_i.
- mem_r_valid_i while pipe_out.valid = 0: response dropped, err_o <= 1. pipe_out.valid with no mem_r_valid_i: err_o <= 1.
- clear_i: ptr_q=0, lock_q=0, pipe flushed, err_o=0; combinational request path unaffected.

## Timing
- Request path req_i → mem_req_o and mem_gnt_i → gnt_o purely combinational (zero latency), per TCDM protocol.
- Response: r_valid_o exactly RESP_LAT cycles after handshake; back-to-back handshakes every cycle sustained.
- Reset values: ptr_q=0, lock_q=0, pipe all invalid, err_o=0, counters 0; outputs gnt_o=0 and r_valid_o=0 when req_i=0 and mem_r_valid_i=0.
- Reset mid-transaction: in-flight responses forgotten; any later mem_r_valid_i flags err_o.
- ptr wrap: winner NR-1 → ptr_q=0.

## Configuration
- TCDM_RR_ARBITER_PERF_EN defined: adds outputs cnt_gnt_o (NR×32, handshakes per requester) and cnt_stall_o (32, cycles with mem_req_o & ~mem_gnt_i); saturating at 2^32-1, zeroed by reset and clear_i.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- NR=4, RESP_LAT=1, req_i=4'b1111 held, mem_gnt_i=1 → grants 0,1,2,3,0 on consecutive cycles; r_valid_o one-hot one cycle later, same order.
- req_i=4'b1010 from reset → grant 1 then 3 then 1; ptr_q skips idle ports.
- req_i=4'b0011, mem_gnt_i=0 for 3 cycles then 1 → mem_add_o = add_i[0] all 4 cycles (locked despite req 1), then requester 1 granted next.
- RESP_LAT=3, reads at add 0x0,0x4,0x8 from requesters 2,0,3 back-to-back → r_valid_o[2],[0],[3] cycles 3,4,5 with matching mem_r_data_i.
- mem_r_valid_i=1 with no handshake outstanding → all r_valid_o=0, err_o=1 until clear_i.
- PERF_EN, 10 handshakes to requester 1 and 4 stall cycles → cnt_gnt_o[1]=10, cnt_stall_o=4; clear_i → both 0.
